alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-cycle controller that runs a wide AND/ADD through the team's 4-bit AND/ADD slice.
//  The slice is combinational, with sel=0 AND and sel=1 ADD; this block is its only driver.
//  Each accepted request is processed one nibble per cycle, LSB nibble first, with the carry chained between nibbles.
//  The full-width result is returned over a valid/ready response channel.
// PARAMETERS
//  NIBBLES   4   number of 4-bit slices per operation; operand width W = 4*NIBBLES (legal 2..8)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   request offered
//  req_ready   out  1   block can accept request (high only in IDLE)
//  req_a       in   W   operand A
//  req_b       in   W   operand B
//  req_sel     in   1   0 = AND, 1 = ADD
//  req_cin     in   1   carry into nibble 0 (ADD only)
//  rsp_valid   out  1   result available
//  rsp_ready   in   1   consumer takes result
//  rsp_result  out  W   AND / ADD result
//  rsp_cout    out  1   carry out of top nibble (0 for AND)
//  alu_a       out  4   slice operand A nibble
//  alu_b       out  4   slice operand B nibble
//  alu_sel     out  1   slice mode
//  alu_c_in    out  1   slice carry-in
//  alu_result  in   4   slice result, sampled in the same cycle
//  alu_c_out   in   1   slice carry-out, sampled in the same cycle
// BEHAVIOUR
//  - States:
//    - IDLE -> RUN on req_valid & req_ready.
//    - RUN -> DONE after the capture at cnt == NIBBLES-1.
//    - DONE -> IDLE on rsp_ready.
//  - Accept edge: latch req_a, req_b, req_sel, req_cin into op regs; cnt <= 0; carry <= req_cin & req_sel.
//  - RUN, each cycle:
//    - alu_a = op_a[4*cnt+:4], alu_b = op_b[4*cnt+:4], alu_sel = op_sel.
//    - alu_c_in = op_sel ? carry : 0.
//    - At the edge: res[4*cnt+:4] <= alu_result; carry <= op_sel ? alu_c_out : 0; cnt++.
//  - Latency: rsp_valid rises exactly NIBBLES edges after the accept edge; no combinational req->rsp path.
//  - In DONE, rsp_result and rsp_cout (= carry) are held stable while rsp_valid=1 and rsp_ready=0.
//  - Back-to-back requests: the next accept is possible no earlier than the cycle after the DONE->IDLE edge (throughput 1 per NIBBLES+2 cycles).
//  - req_* inputs are ignored outside the accept edge; changes during RUN have no effect.
//  - Outside RUN: alu_a = alu_b = 0, alu_sel = 0, alu_c_in = 0.
//  - cnt is clog2(NIBBLES) bits wide; it never wraps, because RUN exits at NIBBLES-1.
//  - Reset (asynchronous, any state, including mid-RUN):
//    - state = IDLE, cnt = 0, carry = 0, op regs = 0, res = 0.
//    - req_ready = 1 immediately after reset deassertion; rsp_valid = 0, rsp_result = 0, rsp_cout = 0.
//    - A partially processed request is dropped and no response is issued.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN (defined):
//    - Adds outputs rsp_zero (1: res == 0) and rsp_ovf (1: signed overflow, ADD only).
//    - rsp_ovf = carry-in XOR carry-out of the top bit; bit 3 of the top nibble is derived from the operand and result sign bits.
//    - Both flags are registered with res, valid with rsp_valid, and reset to 0. They are 0 for AND, except rsp_zero.
//  ALU_SEQ_FLAGS_EN (undefined): neither port exists; all other behaviour is identical.
// TESTING (NIBBLES=4, bench instantiates the 4-bit AND/ADD slice with carry-out exposed)
//  1. ADD 0x00FF + 0x0001, cin=0 -> rsp_result=0x0100, rsp_cout=0; rsp_valid 4 edges after accept.
//  2. ADD 0xFFFF + 0x0000, cin=1 -> rsp_result=0x0000, rsp_cout=1, rsp_zero=1 (flags build).
//  3. AND 0xF0F0 & 0x3C3C, cin=1 -> rsp_result=0x3030, rsp_cout=0; alu_c_in=0 on every RUN cycle.
//  4. Complete ADD with rsp_ready=0 for 3 cycles -> result held stable, req_ready=0 throughout; release -> IDLE the next edge.
//  5. Assert reset after the 2nd nibble of ADD 0x7FFF+0x0001 -> all outputs 0, req_ready=1, no rsp_valid.
//     Next, ADD 0x7FFF+0x0001 -> rsp_result=0x8000, rsp_ovf=1 (flags build).
//  6. Two back-to-back requests with req_valid held high -> second accepted only after first response handshake; both results correct.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Runs a W-bit AND/ADD through an external 4-bit slice, one nibble per cycle, LSB first.
// Optional rsp_zero/rsp_ovf outputs when ALU_SEQ_FLAGS_EN is defined.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_sel,
  input  logic                   req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_result,
  output logic                   rsp_cout,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                   rsp_zero,
  output logic                   rsp_ovf,
`endif
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_sel,
  output logic                   alu_c_in,
  input  logic [3:0]             alu_result,
  input  logic                   alu_c_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           op_sel_q, op_sel_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   a_sh, b_sh;
  logic           last;
`ifdef ALU_SEQ_FLAGS_EN
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sel_d = op_sel_q;
    res_d    = res_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_sel  = 1'b0;
    alu_c_in = 1'b0;
    a_sh     = op_a_q >> {cnt_q, 2'b00};
    b_sh     = op_b_q >> {cnt_q, 2'b00};
    last     = (cnt_q == CW'(NIBBLES - 1));

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = RUN;
          op_a_d   = req_a;
          op_b_d   = req_b;
          op_sel_d = req_sel;
          cnt_d    = '0;
          carry_d  = req_cin & req_sel;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        alu_a    = a_sh[3:0];
        alu_b    = b_sh[3:0];
        alu_sel  = op_sel_q;
        alu_c_in = op_sel_q & carry_q;
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CW'(i)) res_d[4*i +: 4] = alu_result;
        end
        carry_d = op_sel_q & alu_c_out;
        if (last) begin
          state_d = DONE;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d  = (res_d == '0);
          // carry into the sign bit recovered from the sign-bit sum: a ^ b ^ r
          ovf_d   = op_sel_q & (alu_a[3] ^ alu_b[3] ^ alu_result[3] ^ alu_c_out);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= 1'b0;
      res_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      res_q    <= res_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = res_q;
  assign rsp_cout   = carry_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign rsp_zero   = zero_q;
  assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit AND/ADD slice;
// directed cases plus randomized operations checked against whole-word arithmetic.
module tb_alu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_sel, req_cin;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_cout;
  logic [W-1:0] rsp_result;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic         alu_sel, alu_c_in, alu_c_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic         rsp_zero, rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 4-bit AND/ADD slice
  always_comb begin
    logic [4:0] s;
    s          = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c_in};
    alu_result = alu_sel ? s[3:0] : (alu_a & alu_b);
    alu_c_out  = alu_sel ? s[4] : 1'b0;
  end

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, follows it through RUN, holds the response for `hold`
  // cycles, then handshakes. With keep=1, req_valid stays high carrying the next
  // operands so the following call starts from an already-pending request.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                       input logic cin, input int hold, input logic keep,
                       input logic [W-1:0] na, input logic [W-1:0] nb,
                       input logic nsel, input logic ncin);
    logic [31:0] sum, lo_a, lo_b, cin_k, mask;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    sum      = {16'b0, a} + {16'b0, b} + {31'b0, sel & cin};
    exp_res  = sel ? sum[W-1:0] : (a & b);
    exp_cout = sel ? sum[W] : 1'b0;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_cin = cin;
    tick();
    if (keep) begin
      req_a = na; req_b = nb; req_sel = nsel; req_cin = ncin;
    end else begin
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom); req_sel = 1'($urandom); req_cin = 1'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      mask  = (32'd1 << (4 * k)) - 32'd1;
      lo_a  = {16'b0, a} & mask;
      lo_b  = {16'b0, b} & mask;
      cin_k = (lo_a + lo_b + {31'b0, sel & cin}) >> (4 * k);
      check("run_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("run_req_ready", {31'b0, req_ready}, 32'd0);
      check("run_alu_a", {28'b0, alu_a}, {28'b0, 4'(a >> (4 * k))});
      check("run_alu_b", {28'b0, alu_b}, {28'b0, 4'(b >> (4 * k))});
      check("run_alu_sel", {31'b0, alu_sel}, {31'b0, sel});
      check("run_alu_c_in", {31'b0, alu_c_in}, sel ? {31'b0, cin_k[0]} : 32'd0);
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rsp_result", {16'b0, rsp_result}, {16'b0, exp_res});
      check("rsp_cout", {31'b0, rsp_cout}, {31'b0, exp_cout});
      check("done_req_ready", {31'b0, req_ready}, 32'd0);
      check("done_alu_a", {28'b0, alu_a}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("rsp_zero", {31'b0, rsp_zero}, {31'b0, exp_res == '0});
      check("rsp_ovf", {31'b0, rsp_ovf},
            {31'b0, sel & (a[W-1] == b[W-1]) & (exp_res[W-1] != a[W-1])});
`endif
      if (h == hold) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = 1'b0;
    req_cin = 1'b0; rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_result", {16'b0, rsp_result}, 32'd0);
    check("rst_rsp_cout", {31'b0, rsp_cout}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_alu_sel", {31'b0, alu_sel}, 32'd0);

    do_op(16'h00FF, 16'h0001, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, 0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_op(16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_op(16'h1234, 16'h8765, 1'b1, 1'b1, 3, 1'b0, '0, '0, 1'b0, 1'b0);

    // reset in the middle of a run
    req_valid = 1'b1; req_a = 16'h7FFF; req_b = 16'h0001; req_sel = 1'b1; req_cin = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_result", {16'b0, rsp_result}, 32'd0);
    check("mid_rst_rsp_cout", {31'b0, rsp_cout}, 32'd0);
    check("mid_rst_alu_a", {28'b0, alu_a}, 32'd0);
    check("mid_rst_alu_c_in", {31'b0, alu_c_in}, 32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    reset = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      tick();
      check("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
    end
    do_op(16'h7FFF, 16'h0001, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0);

    // back-to-back with req_valid held high
    do_op(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 1, 1'b1, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    do_op(16'hFF00, 16'h0FF0, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 1'b0, '0, '0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
